// File: rtl/vec_activation_pkg.sv
// Shared types and helpers for the chunked lane-parallel activation stage.
// Imported by the lane sub-module and by the top level.
package act_pkg;

   typedef enum logic [1:0] {
      ACT_PASS  = 2'd0,
      ACT_RELU  = 2'd1,
      ACT_LEAKY = 2'd2,
      ACT_CLIP  = 2'd3
   } act_mode_t;

   typedef enum logic {
      IDLE   = 1'b0,
      STREAM = 1'b1
   } act_state_t;

   function automatic int num_chunks(input int len, input int lanes);
      return (len + lanes - 1) / lanes;
   endfunction

endpackage

// File: rtl/vec_activation_if.sv
// Chunk stream bundle: upstream show-ahead FIFO head/pop and downstream push/backpressure.
// The master side feeds chunks and sinks results; the slave side is the activation unit.
interface vec_activation_if #(
   parameter int WorkingRegs = 4,
   parameter int DataWidth   = 8
);

   logic                               in_data_ready;
   logic [WorkingRegs*DataWidth-1:0]   in_data;
   logic                               req_chunk_in;
   logic                               out_ready_in;
   logic [WorkingRegs*DataWidth-1:0]   write_out_data;
   logic                               req_chunk_out;
   logic                               out_vector_valid;

   modport master (
      output in_data_ready, in_data, out_ready_in,
      input  req_chunk_in, write_out_data, req_chunk_out, out_vector_valid
   );

   modport slave (
      input  in_data_ready, in_data, out_ready_in,
      output req_chunk_in, write_out_data, req_chunk_out, out_vector_valid
   );

endinterface

// File: rtl/vec_activation_lane.sv
// One combinational activation lane: passthrough, ReLU, leaky ReLU or clipped ReLU.
// Every result fits in DataWidth, so no saturation is needed.
module act_lane
   import act_pkg::*;
#(
   parameter int DataWidth = 8,
   parameter int LeakShift = 3
) (
   input  act_mode_t                   mode,
   input  logic signed [DataWidth-1:0] clip,
   input  logic signed [DataWidth-1:0] x,
   output logic signed [DataWidth-1:0] y
);

   always_comb begin
      y = x;
      unique case (mode)
         ACT_PASS:  y = x;
         ACT_RELU:  y = x[DataWidth-1] ? '0 : x;
         ACT_LEAKY: y = x[DataWidth-1] ? (x >>> LeakShift) : x;
         ACT_CLIP: begin
            // A negative clip bound collapses every output to zero
            if (x[DataWidth-1] || clip[DataWidth-1]) y = '0;
            else if (x > clip)                       y = clip;
            else                                     y = x;
         end
         default:   y = x;
      endcase
   end

endmodule

// File: rtl/vec_activation.sv
// Chunked elementwise activation between two layer FIFOs: pops a chunk, applies the
// activation latched at vector start, and holds the registered result until pushed.
module vec_activation
   import act_pkg::*;
#(
   parameter int InVecLength = 16,
   parameter int WorkingRegs = 4,
   parameter int DataWidth   = 8,
   parameter int LeakShift   = 3
) (
   input  logic                        clk_in,
   input  logic                        rst_in,
   input  logic [1:0]                  mode_in,
   input  logic signed [DataWidth-1:0] clip_in,
   vec_activation_if.slave             bus,
   output logic                        busy
);

   localparam int NumChunks = num_chunks(InVecLength, WorkingRegs);
   localparam int IdxWidth  = (NumChunks > 1) ? $clog2(NumChunks) : 1;
   localparam logic [IdxWidth-1:0] LastIdx = IdxWidth'(NumChunks - 1);

   act_state_t                       state_q, state_d;
   logic [IdxWidth-1:0]              chunk_idx_q, chunk_idx_d;
   act_mode_t                        mode_q, cur_mode;
   logic signed [DataWidth-1:0]      clip_q, cur_clip;
   logic                             out_full_q;
   logic                             out_last_q;
   logic [WorkingRegs*DataWidth-1:0] out_data_q;
   logic [WorkingRegs*DataWidth-1:0] lane_result;
   logic                             pop, push, is_last;

   assign pop     = bus.in_data_ready && (!out_full_q || bus.out_ready_in);
   assign push    = out_full_q && bus.out_ready_in;
   assign is_last = (chunk_idx_q == LastIdx);

   // The first chunk of a vector is processed with the settings being latched this cycle
   assign cur_mode = (state_q == IDLE) ? act_mode_t'(mode_in) : mode_q;
   assign cur_clip = (state_q == IDLE) ? clip_in : clip_q;

   for (genvar g = 0; g < WorkingRegs; g++) begin : g_lane
      localparam bit PadLane = ((NumChunks - 1) * WorkingRegs + g) >= InVecLength;
      logic signed [DataWidth-1:0] x, y;
      assign x = bus.in_data[g*DataWidth +: DataWidth];
      act_lane #(.DataWidth(DataWidth), .LeakShift(LeakShift)) u_lane (
         .mode (cur_mode),
         .clip (cur_clip),
         .x    (x),
         .y    (y)
      );
      assign lane_result[g*DataWidth +: DataWidth] = (PadLane && is_last) ? '0 : y;
   end

   always_comb begin
      state_d     = state_q;
      chunk_idx_d = chunk_idx_q;
      if (pop) begin
         if (is_last) begin
            chunk_idx_d = '0;
            state_d     = IDLE;
         end else begin
            chunk_idx_d = chunk_idx_q + IdxWidth'(1);
            state_d     = STREAM;
         end
      end
   end

   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         state_q     <= IDLE;
         chunk_idx_q <= '0;
         mode_q      <= ACT_RELU;
         clip_q      <= '0;
      end else begin
         state_q     <= state_d;
         chunk_idx_q <= chunk_idx_d;
         if (pop && state_q == IDLE) begin
            mode_q <= act_mode_t'(mode_in);
            clip_q <= clip_in;
         end
      end
   end

   // A pop always refills the register, so a simultaneous push never empties it
   always_ff @(posedge clk_in or posedge rst_in) begin
      if (rst_in) begin
         out_full_q <= 1'b0;
         out_last_q <= 1'b0;
         out_data_q <= '0;
      end else if (pop) begin
         out_full_q <= 1'b1;
         out_last_q <= is_last;
         out_data_q <= lane_result;
      end else if (push) begin
         out_full_q <= 1'b0;
      end
   end

   assign bus.req_chunk_in     = pop;
   assign bus.req_chunk_out    = push;
   assign bus.out_vector_valid = push && out_last_q;
   assign bus.write_out_data   = out_data_q;
   assign busy                 = (state_q == STREAM);

endmodule
